multicycle_controller: RTL
==========================

# multicycle_controller

Control sequencer for the multicycle LEGv8 datapath. Replaces the single-cycle combinational decoder: steps every instruction through fetch, decode, execute, memory and write-back states, driving the shared ALU, sign-extend, register-file and unified memory enables one state at a time. Waits on a memory ready handshake during fetch and data access. Supported opcodes are ADD, SUB, AND, ORR, LDUR, STUR and CBZ.

## Interface
Parameters:
- none; opcodes and state encodings come from the shared package

Ports:
- clk  input  1  system clock, rising edge active
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- op  input  11  instr[31:21] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current read or write this cycle
- pc_write  output  1  load the PC
- pc_src  output  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target)
- ir_write  output  1  load the instruction register
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register-file write
- reg2loc  output  1  read port 2 address: 0 = Rm, 1 = Rt
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = signext, 11 = signext << 2
- alu_op  output  2  ALU operation: 00 = add, 01 = pass B, 10 = R-type decode from op
- mem_to_reg  output  1  write-back source: 0 = ALUOut, 1 = MDR
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- state  output  4  current state, for debug and bench

## Operation
- Decode:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LDUR 11111000010, STUR 11111000000
  - CBZ when op[10:3] = 10110100
  - anything else is illegal
- FETCH:
  - Outputs: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready=1: ir_write=1 and pc_write=1 (PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Computes the branch target: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state: R-type → EXEC_R; LDUR/STUR → ADDR; CBZ → BRANCH; illegal → see Configuration.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, reg2loc=0 → WB_R.
- WB_R: reg_write=1, mem_to_reg=0, instr_done=1 → FETCH.
- ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - LDUR → MEM_RD; STUR → MEM_WR (reg2loc=1 in ADDR and MEM_WR).
- MEM_RD: mem_read=1; stays until mem_ready, then → WB_MEM.
- MEM_WR:
  - mem_write=1; stays until mem_ready.
  - On mem_ready: instr_done=1 → FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1 → FETCH.
- BRANCH:
  - reg2loc=1, alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero; instr_done=1 → FETCH.
- All outputs not listed for a state are 0.
- Outputs are Moore-decoded from state. The exceptions are the mem_ready- and zero-qualified enables listed above.

## Timing
- Reset:
  - state←FETCH.
  - While reset=1, every control output is forced to 0, including the FETCH outputs, and state reads FETCH.
- Reset asserted mid-instruction (including a MEM_WR or MEM_RD wait) aborts the instruction. No write enable is asserted during reset.
- Latency with mem_ready held high: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3.
- Each extra cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in every other state.
- mem_read and mem_write are never asserted in the same cycle.
- instr_done is high for exactly one cycle per retired instruction.

## Configuration
- MULTICYCLE_CTRL_EXC_EN defined:
  - An illegal op in DECODE → EXC.
  - EXC holds exc=1 (extra 1-bit output port) and has no write enables.
  - EXC stays until reset.
- Macro undefined:
  - No exc port.
  - An illegal op is a NOP: DECODE asserts instr_done=1 and goes to FETCH (2 cycles total).

## Structure
- Package multicycle_pkg:
  - state_t enum: FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, EXC; 4 bits, FETCH = 0
  - opcode localparams
  - alu_src_b and alu_op constants
- One sub-module, op_class_decode: combinational map op → {is_rtype, is_ldur, is_stur, is_cbz, is_illegal}.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- ADD (op 10001011000), mem_ready=1:
  - State sequence FETCH, DECODE, EXEC_R, WB_R.
  - reg_write=1 only in WB_R; instr_done pulses in cycle 4.
- LDUR (op 11111000010), mem_ready low for 2 cycles in MEM_RD:
  - Takes 7 cycles.
  - mem_read held through the wait; WB_MEM has mem_to_reg=1, reg_write=1.
- STUR (op 11111000000), mem_ready=1:
  - MEM_WR asserts mem_write=1 and reg2loc=1 for 1 cycle.
  - reg_write is never asserted.
- CBZ (op 10110100xxx):
  - zero=1 → pc_write=1 with pc_src=1 in BRANCH.
  - zero=0 → pc_write=0.
  - Both cases take 3 cycles.
- Reset asserted during a MEM_WR wait:
  - All outputs are 0 that cycle; the next state is FETCH.
  - No mem_write is asserted after reset.
- Illegal op (op 10011011000, MUL):
  - With MULTICYCLE_CTRL_EXC_EN: reaches EXC, exc=1, and stays there for 10 cycles.
  - Without the macro: NOP in 2 cycles, with instr_done pulsing in DECODE.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle LEGv8 control sequencer: states, opcodes, ALU mux/op codes.
// Optional exception state is only reachable when MULTICYCLE_CTRL_EXC_EN is defined.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_MEM = 4'd7,
    BRANCH = 4'd8,
    EXC    = 4'd9
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ is identified by its top 8 bits only; the low 3 bits belong to the immediate.
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  localparam logic [1:0] ALUB_REG      = 2'b00;
  localparam logic [1:0] ALUB_FOUR     = 2'b01;
  localparam logic [1:0] ALUB_SEXT     = 2'b10;
  localparam logic [1:0] ALUB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic is_rtype;
    logic is_ldur;
    logic is_stur;
    logic is_cbz;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// The exc line exists only when MULTICYCLE_CTRL_EXC_EN is defined.
interface multicycle_controller_if;

  logic [10:0] op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        reg2loc;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_to_reg;
  logic        instr_done;
  logic [3:0]  state;
`ifdef MULTICYCLE_CTRL_EXC_EN
  logic        exc;
`endif

  modport master (
    input  op, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg2loc,
    output alu_src_a, alu_src_b, alu_op, mem_to_reg, instr_done, state
`ifdef MULTICYCLE_CTRL_EXC_EN
    , output exc
`endif
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg2loc,
    input  alu_src_a, alu_src_b, alu_op, mem_to_reg, instr_done, state
`ifdef MULTICYCLE_CTRL_EXC_EN
    , input exc
`endif
  );

endinterface

// File: rtl/multicycle_controller_op_class_decode.sv
// Combinational opcode classifier: instr[31:21] -> one-hot instruction class.
// Exactly one class bit is set for any op; unknown encodings land in is_illegal.
module op_class_decode
  import multicycle_pkg::*;
(
  input  logic [10:0] i_op,
  output op_class_t   o_cls
);

  logic w_rtype;
  logic w_ldur;
  logic w_stur;
  logic w_cbz;

  always_comb begin
    w_rtype = (i_op == OP_ADD) || (i_op == OP_SUB) || (i_op == OP_AND) || (i_op == OP_ORR);
    w_ldur  = (i_op == OP_LDUR);
    w_stur  = (i_op == OP_STUR);
    w_cbz   = (i_op[10:3] == OP_CBZ_HI);

    o_cls            = '0;
    o_cls.is_rtype   = w_rtype;
    o_cls.is_ldur    = w_ldur;
    o_cls.is_stur    = w_stur;
    o_cls.is_cbz     = w_cbz;
    o_cls.is_illegal = !(w_rtype || w_ldur || w_stur || w_cbz);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 control sequencer: Moore-decoded enables, qualified by mem_ready/zero where noted.
// MULTICYCLE_CTRL_EXC_EN: illegal ops trap into a sticky EXC state instead of retiring as NOPs.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  state_t    r_state;
  state_t    w_next;
  op_class_t w_cls;

  logic       w_pc_write;
  logic       w_pc_src;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg2loc;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_mem_to_reg;
  logic       w_instr_done;
`ifdef MULTICYCLE_CTRL_EXC_EN
  logic       w_exc;
`endif

  op_class_decode u_op_class_decode (
    .i_op  (bus.op),
    .o_cls (w_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        if (w_cls.is_illegal) begin
`ifdef MULTICYCLE_CTRL_EXC_EN
          w_next = EXC;
`else
          w_next = FETCH;
`endif
        end else if (w_cls.is_rtype) begin
          w_next = EXEC_R;
        end else if (w_cls.is_ldur || w_cls.is_stur) begin
          w_next = ADDR;
        end else begin
          w_next = BRANCH;
        end
      end
      EXEC_R:  w_next = WB_R;
      WB_R:    w_next = FETCH;
      ADDR:    w_next = w_cls.is_ldur ? MEM_RD : MEM_WR;
      MEM_RD:  if (bus.mem_ready) w_next = WB_MEM;
      MEM_WR:  if (bus.mem_ready) w_next = FETCH;
      WB_MEM:  w_next = FETCH;
      BRANCH:  w_next = FETCH;
`ifdef MULTICYCLE_CTRL_EXC_EN
      EXC:     w_next = EXC;
`endif
      default: w_next = FETCH;
    endcase
  end

  // Everything is gated by reset so no enable can fire while an instruction is being aborted.
  always_comb begin
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg2loc    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = ALUB_REG;
    w_alu_op     = ALUOP_ADD;
    w_mem_to_reg = 1'b0;
    w_instr_done = 1'b0;
`ifdef MULTICYCLE_CTRL_EXC_EN
    w_exc        = 1'b0;
`endif
    if (!reset) begin
      case (r_state)
        FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = ALUB_FOUR;
          w_ir_write  = bus.mem_ready;
          w_pc_write  = bus.mem_ready;
        end
        DECODE: begin
          w_alu_src_b = ALUB_SEXT_SH2;
`ifndef MULTICYCLE_CTRL_EXC_EN
          w_instr_done = w_cls.is_illegal;
`endif
        end
        EXEC_R: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = ALUOP_RTYPE;
        end
        WB_R: begin
          w_reg_write  = 1'b1;
          w_instr_done = 1'b1;
        end
        ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = ALUB_SEXT;
          w_reg2loc   = w_cls.is_stur;
        end
        MEM_RD:  w_mem_read = 1'b1;
        MEM_WR: begin
          w_mem_write  = 1'b1;
          w_reg2loc    = 1'b1;
          w_instr_done = bus.mem_ready;
        end
        WB_MEM: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
          w_instr_done = 1'b1;
        end
        BRANCH: begin
          w_reg2loc    = 1'b1;
          w_alu_src_a  = 1'b1;
          w_alu_op     = ALUOP_PASSB;
          w_pc_src     = 1'b1;
          w_pc_write   = bus.zero;
          w_instr_done = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_EXC_EN
        EXC:     w_exc = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.pc_src     = w_pc_src;
  assign bus.ir_write   = w_ir_write;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.reg2loc    = w_reg2loc;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.instr_done = w_instr_done;
  assign bus.state      = reset ? FETCH : r_state;
`ifdef MULTICYCLE_CTRL_EXC_EN
  assign bus.exc        = w_exc;
`endif

endmodule
